// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit_pkg : shared pipeline constants and target helpers for IF stage
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam logic [4:0]  EXC_SYSCALL        = 5'd8;
   localparam logic [4:0]  EXC_RI             = 5'd10;
   localparam logic [4:0]  EXC_ADEL           = 5'd4;
   localparam logic [4:0]  EXC_NONE           = 5'd0;
   localparam logic [31:0] INST_NOP           = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0008;

   function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                 input logic [15:0] imm16);
      return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                               input logic [25:0] idx26);
      return {pc4[31:28], idx26, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// next_pc_sel : combinational next-PC priority mux and exception decode
// Rev 1.0
// ---------------------------------------------------------------------------
module next_pc_sel
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
   input  logic [31:0] pc_i,
   input  logic [31:0] id_pc4_i,
   input  logic [25:0] inst_idx_i,
   input  logic [31:0] epc_i,
   input  logic        id_beq_i,
   input  logic        id_bne_i,
   input  logic        id_j_i,
   input  logic        id_jr_i,
   input  logic        id_syscall_i,
   input  logic        id_unknown_i,
   input  logic        id_eret_i,
   input  logic        rs_eq_i,
   input  logic [31:0] rs_val_i,
   output logic [31:0] next_pc_o,
   output logic        redirect_o,
   output logic        exc_valid_o,
   output logic [4:0]  exc_code_o
);

   logic w_taken;
   logic w_adel;

   always_comb begin
      w_taken     = (id_beq_i & rs_eq_i) | (id_bne_i & ~rs_eq_i);
      w_adel      = id_jr_i & (rs_val_i[1:0] != 2'b00);
      exc_valid_o = id_syscall_i | id_unknown_i | w_adel;

      exc_code_o = EXC_NONE;
      if (id_syscall_i)      exc_code_o = EXC_SYSCALL;
      else if (id_unknown_i) exc_code_o = EXC_RI;
      else if (w_adel)       exc_code_o = EXC_ADEL;

      next_pc_o  = pc_i + 32'd4;
      redirect_o = 1'b1;
      if (exc_valid_o)    next_pc_o = EXC_VECTOR;
      else if (id_eret_i) next_pc_o = epc_i;
      else if (id_jr_i)   next_pc_o = rs_val_i;
      else if (id_j_i)    next_pc_o = jump_target(id_pc4_i, inst_idx_i);
      else if (w_taken)   next_pc_o = branch_target(id_pc4_i, inst_idx_i[15:0]);
      else                redirect_o = 1'b0;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : IF stage holding PC, IF/ID register and EPC/cause/EXL state
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc4,
   input  logic        id_beq,
   input  logic        id_bne,
   input  logic        id_j,
   input  logic        id_jr,
   input  logic        id_syscall,
   input  logic        id_unknown,
   input  logic        id_eret,
   input  logic        rs_eq,
   input  logic [31:0] rs_val,
   output logic        redirect,
   output logic [31:0] epc,
   output logic [4:0]  cause,
   output logic        exl
);

   logic [31:0] pc_q,    pc_d;
   logic [31:0] inst_q,  inst_d;
   logic [31:0] pc4_q,   pc4_d;
   logic [31:0] epc_q,   epc_d;
   logic [4:0]  cause_q, cause_d;
   logic        exl_q,   exl_d;

   logic [31:0] sel_next_pc;
   logic        sel_redirect;
   logic        sel_exc_valid;
   logic [4:0]  sel_exc_code;

   next_pc_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc_sel (
      .pc_i         (pc_q),
      .id_pc4_i     (pc4_q),
      .inst_idx_i   (inst_q[25:0]),
      .epc_i        (epc_q),
      .id_beq_i     (id_beq),
      .id_bne_i     (id_bne),
      .id_j_i       (id_j),
      .id_jr_i      (id_jr),
      .id_syscall_i (id_syscall),
      .id_unknown_i (id_unknown),
      .id_eret_i    (id_eret),
      .rs_eq_i      (rs_eq),
      .rs_val_i     (rs_val),
      .next_pc_o    (sel_next_pc),
      .redirect_o   (sel_redirect),
      .exc_valid_o  (sel_exc_valid),
      .exc_code_o   (sel_exc_code)
   );

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      pc4_d   = pc4_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      exl_d   = exl_q;
      // A stalled ID instruction keeps its redirect pending until stall drops.
      if (!stall) begin
         pc_d = sel_next_pc;
         if (sel_redirect) begin
            inst_d = INST_NOP;
            pc4_d  = 32'd0;
         end else begin
            inst_d = imem_rdata;
            pc4_d  = pc_q + 32'd4;
         end
         if (sel_exc_valid) begin
            cause_d = sel_exc_code;
            if (!exl_q) begin
               epc_d = pc4_q - 32'd4;
               exl_d = 1'b1;
            end
         end else if (id_eret) begin
            exl_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         inst_q  <= INST_NOP;
         pc4_q   <= 32'd0;
         epc_q   <= 32'd0;
         cause_q <= EXC_NONE;
         exl_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pc4_q   <= pc4_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         exl_q   <= exl_d;
      end
   end

   assign imem_addr = pc_q;
   assign id_inst   = inst_q;
   assign id_pc4    = pc4_q;
   assign redirect  = sel_redirect & ~stall;
   assign epc       = epc_q;
   assign cause     = cause_q;
   assign exl       = exl_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : vector table, directed corner sequences and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk, rst_n, stall;
   logic [31:0] imem_addr, imem_rdata, tb_rdata;
   logic [31:0] id_inst, id_pc4, rs_val, epc;
   logic        id_beq, id_bne, id_j, id_jr, id_syscall, id_unknown, id_eret;
   logic        rs_eq, redirect, exl, use_rom;
   logic [4:0]  cause;

   int checks = 0;
   int fails  = 0;

   // Reference state: what the IF stage architecturally holds.
   logic [31:0] m_pc, m_inst, m_pc4, m_epc;
   logic [4:0]  m_cause;
   logic        m_exl;

   typedef struct {
      logic [31:0] fa;
      logic [31:0] inst;
      logic        beq, bne, j, jr, eq;
      logic [31:0] rsv;
      logic [31:0] exp_pc;
      logic        exp_redir;
   } vec_t;
   vec_t tbl [9];

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5A5, a[15:0]};
   endfunction

   assign imem_rdata = use_rom ? rom(imem_addr) : tb_rdata;

   fetch_unit #(.RESET_PC(32'h0), .EXC_VECTOR(32'h8)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_inst(id_inst), .id_pc4(id_pc4),
      .id_beq(id_beq), .id_bne(id_bne), .id_j(id_j), .id_jr(id_jr),
      .id_syscall(id_syscall), .id_unknown(id_unknown), .id_eret(id_eret),
      .rs_eq(rs_eq), .rs_val(rs_val), .redirect(redirect),
      .epc(epc), .cause(cause), .exl(exl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic clear_flags();
      {id_beq, id_bne, id_j, id_jr, id_syscall, id_unknown, id_eret} = '0;
      rs_eq = 1'b0;
      stall = 1'b0;
   endtask

   task automatic mdl_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0;
      m_epc = 32'h0; m_cause = 5'd0; m_exl = 1'b0;
   endtask

   // Next PC from the architectural rules, highest priority first.
   task automatic mdl_eval(output logic [31:0] nxt, output logic redir,
                           output logic exc, output logic [4:0] code);
      logic signed [31:0] off;
      logic               adel, taken;
      off   = $signed(m_inst[15:0]);
      adel  = id_jr && (rs_val % 4 != 0);
      taken = (id_beq && rs_eq) || (id_bne && !rs_eq);
      exc   = id_syscall || id_unknown || adel;
      code  = id_syscall ? 5'd8 : id_unknown ? 5'd10 : adel ? 5'd4 : 5'd0;
      redir = 1'b1;
      if (exc)          nxt = 32'h8;
      else if (id_eret) nxt = m_epc;
      else if (id_jr)   nxt = rs_val;
      else if (id_j)    nxt = {m_pc4[31:28], m_inst[25:0], 2'b00};
      else if (taken)   nxt = m_pc4 + 32'(off * 4);
      else begin
         nxt   = m_pc + 32'd4;
         redir = 1'b0;
      end
   endtask

   // Compare all outputs against the model, then advance one clock.
   task automatic step();
      logic [31:0] nxt, rd;
      logic        redir, exc;
      logic [4:0]  code;
      #1;
      mdl_eval(nxt, redir, exc, code);
      rd = use_rom ? rom(m_pc) : tb_rdata;
      chk("imem_addr", imem_addr, m_pc);
      chk("id_inst", id_inst, m_inst);
      chk("id_pc4", id_pc4, m_pc4);
      chk("epc", epc, m_epc);
      chk("cause", {27'd0, cause}, {27'd0, m_cause});
      chk("exl", {31'd0, exl}, {31'd0, m_exl});
      chk("redirect", {31'd0, redirect}, {31'd0, redir & ~stall});
      @(posedge clk);
      #1;
      if (!stall) begin
         if (exc) begin
            m_cause = code;
            if (!m_exl) begin
               m_epc = m_pc4 - 32'd4;
               m_exl = 1'b1;
            end
         end else if (id_eret) begin
            m_exl = 1'b0;
         end
         m_inst = redir ? 32'h0 : rd;
         m_pc4  = redir ? 32'h0 : m_pc + 32'd4;
         m_pc   = nxt;
      end
   endtask

   // Jump fetch to addr and load inst into ID with id_pc4 = addr + 4.
   task automatic goto_id(input logic [31:0] addr, input logic [31:0] inst);
      clear_flags();
      id_jr  = 1'b1;
      rs_val = addr;
      step();
      clear_flags();
      tb_rdata = inst;
      step();
   endtask

   initial begin
      tbl[0] = '{32'h10, 32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1};
      tbl[1] = '{32'h10, 32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h18, 1'b0};
      tbl[2] = '{32'h20, 32'h1400_0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h30, 1'b1};
      tbl[3] = '{32'h20, 32'h1400_0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h28, 1'b0};
      tbl[4] = '{32'h1000_000C, 32'h0800_0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                 32'h1000_0100, 1'b1};
      tbl[5] = '{32'h50, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h200, 1'b1};
      tbl[6] = '{32'hFFFF_FFF8, 32'h1000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1};
      tbl[7] = '{32'hFFFF_FFF8, 32'h1000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
      tbl[8] = '{32'hFFFF_0000, 32'h1000_7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,
                 32'h0001_0000, 1'b1};

      // Reset values, then sequential fetch from an address-dependent ROM.
      rst_n = 1'b0; use_rom = 1'b1; tb_rdata = 32'h0; rs_val = 32'h0;
      clear_flags();
      mdl_reset();
      #12;
      chk("rst_pc", imem_addr, 32'h0);
      chk("rst_inst", id_inst, 32'h0);
      chk("rst_pc4", id_pc4, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_cause_exl", {26'd0, cause, exl}, 32'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("seq_addr", imem_addr, 32'(4 * k));
         chk("seq_inst", id_inst, rom(32'(4 * (k - 1))));
      end

      // Control-flow vectors.
      use_rom = 1'b0;
      for (int i = 0; i < 9; i++) begin
         goto_id(tbl[i].fa, tbl[i].inst);
         id_beq = tbl[i].beq; id_bne = tbl[i].bne; id_j = tbl[i].j; id_jr = tbl[i].jr;
         rs_eq  = tbl[i].eq;  rs_val = tbl[i].rsv;
         tb_rdata = 32'hC0DE_0000 + 32'(i);
         #1;
         chk("vec_redirect", {31'd0, redirect}, {31'd0, tbl[i].exp_redir});
         step();
         chk("vec_pc", imem_addr, tbl[i].exp_pc);
         chk("vec_inst", id_inst, tbl[i].exp_redir ? 32'h0 : 32'hC0DE_0000 + 32'(i));
      end

      // syscall, nested unknown at exl=1, then eret.
      goto_id(32'h40, 32'h0000_000C);
      id_syscall = 1'b1;
      step();
      chk("sys_pc", imem_addr, 32'h8);
      chk("sys_epc", epc, 32'h40);
      chk("sys_cause", {27'd0, cause}, 32'd8);
      chk("sys_exl", {31'd0, exl}, 32'd1);
      clear_flags(); tb_rdata = 32'hFFFF_FFFF;
      step();
      id_unknown = 1'b1;
      step();
      chk("ri_cause", {27'd0, cause}, 32'd10);
      chk("ri_epc", epc, 32'h40);
      chk("ri_pc", imem_addr, 32'h8);
      clear_flags();
      step();
      id_eret = 1'b1;
      step();
      chk("eret_pc", imem_addr, 32'h40);
      chk("eret_exl", {31'd0, exl}, 32'd0);

      // Misaligned jr raises address error.
      goto_id(32'h80, 32'h0000_0008);
      id_jr = 1'b1; rs_val = 32'h0000_0202;
      step();
      chk("adel_pc", imem_addr, 32'h8);
      chk("adel_cause", {27'd0, cause}, 32'd4);
      chk("adel_epc", epc, 32'h80);
      clear_flags();
      step();
      id_eret = 1'b1;
      step();

      // Stall holds a taken bne in ID for three cycles.
      goto_id(32'h100, 32'h1400_0004);
      id_bne = 1'b1; rs_eq = 1'b0; stall = 1'b1; tb_rdata = 32'h1234_5678;
      repeat (3) begin
         #1;
         chk("stall_redirect", {31'd0, redirect}, 32'd0);
         step();
         chk("stall_pc", imem_addr, 32'h104);
         chk("stall_inst", id_inst, 32'h1400_0004);
      end
      stall = 1'b0;
      #1;
      chk("unstall_redirect", {31'd0, redirect}, 32'd1);
      step();
      chk("unstall_pc", imem_addr, 32'h114);
      chk("unstall_inst", id_inst, 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         clear_flags();
         case ($urandom_range(0, 15))
            0: id_syscall = 1'b1;
            1: id_unknown = 1'b1;
            2: id_eret    = 1'b1;
            3: id_jr      = 1'b1;
            4: id_j       = 1'b1;
            5: id_beq     = 1'b1;
            6: id_bne     = 1'b1;
            default: ;
         endcase
         rs_eq    = 1'($urandom_range(0, 1));
         rs_val   = $urandom;
         if ($urandom_range(0, 3) != 0) rs_val[1:0] = 2'b00;
         stall    = ($urandom_range(0, 4) == 0);
         tb_rdata = $urandom;
         step();
      end

      // Asynchronous reset between edges while a taken beq is in ID.
      goto_id(32'h60, 32'h1000_0010);
      id_beq = 1'b1; rs_eq = 1'b1;
      #3;
      chk("pre_rst_redirect", {31'd0, redirect}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_pc", imem_addr, 32'h0);
      chk("arst_inst", id_inst, 32'h0);
      chk("arst_pc4", id_pc4, 32'h0);
      chk("arst_epc", epc, 32'h0);
      chk("arst_cause_exl", {26'd0, cause, exl}, 32'h0);
      mdl_reset();
      clear_flags();
      @(posedge clk);
      #1;
      chk("arst_hold_pc", imem_addr, 32'h0);
      rst_n = 1'b1;
      step();
      chk("post_rst_pc", imem_addr, 32'h4);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
